clk_div_bank: RTL

Multi-channel programmable clock/tick divider that generalises the team's fixed single-output divide-by-toggle block. It has NCH independent channels, each with a run-time loadable divisor and a per-channel output mode: 50%-duty square wave or single-cycle tick. Divisor and mode updates are shadowed and take effect only at a terminal count, so outputs never glitch or shorten a period. It sits next to the board clock and feeds slow strobes, such as display refresh, debouncers and LED blink, to the rest of the design.

---
 rtl/clk_div_bank.sv | 121 ++++++++++++
 1 files changed

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - multi-channel programmable clock/tick divider with shadowed reload
//
// Purpose: NCH independent dividers. Each channel has a loadable divisor D and
// an output mode. Toggle mode gives a 50%-duty square wave of period 2*(D+1).
// Pulse mode gives a one-cycle pulse every D+1 cycles. Divisor and mode writes
// go into a shadow register and are applied at the next terminal count, or on
// the next edge if the channel is disabled. This keeps every period whole.
//
// Ports:
//   clk      system clock, all state on posedge
//   rst_n    asynchronous active-low reset
//   en       per-channel run enable
//   wr_en    write strobe
//   wr_sel   channel to write (values >= NCH ignored)
//   wr_div   new divisor D
//   wr_mode  new mode (0 = toggle, 1 = pulse)
//   clk_out  divided output per channel (registered)
//   tick     one-cycle strobe at each terminal count (registered)
//   pend     shadow load waiting to be applied
module clk_div_bank #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 26,
  parameter int DEF_DIV = 33333332,
  parameter int SEL_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_mode,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pend
);

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt     [NCH];
  logic [CNT_W-1:0] act_div [NCH];
  logic [CNT_W-1:0] sh_div  [NCH];
  logic [NCH-1:0]   act_mode;
  logic [NCH-1:0]   sh_mode;

  logic [NCH-1:0]   term;    // running channel at its terminal count this edge
  logic [NCH-1:0]   apply;   // shadow moves into the active registers this edge
  logic [NCH-1:0]   mchg;    // that move changes the mode, so clk_out restarts low
  logic [NCH-1:0]   wr_hit;  // this channel is the write target

  always_comb begin
    term   = '0;
    apply  = '0;
    mchg   = '0;
    wr_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      term[i]   = en[i] && (cnt[i] == act_div[i]);
      // A disabled channel has no period to protect, so it applies at once.
      apply[i]  = pend[i] && (term[i] || !en[i]);
      mchg[i]   = apply[i] && (sh_mode[i] != act_mode[i]);
      // Selects >= NCH match no index and fall through harmlessly.
      wr_hit[i] = wr_en && (wr_sel == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]     <= '0;
        act_div[i] <= DEF;
        sh_div[i]  <= DEF;
      end
      act_mode <= '0;
      sh_mode  <= '0;
      pend     <= '0;
      clk_out  <= '0;
      tick     <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (en[i]) begin
          if (term[i]) begin
            cnt[i]  <= '0;
            tick[i] <= 1'b1;
            if (mchg[i])
              clk_out[i] <= 1'b0;
            else if (act_mode[i])
              clk_out[i] <= 1'b1;
            else
              clk_out[i] <= ~clk_out[i];
          end else begin
            cnt[i]  <= cnt[i] + 1'b1;
            tick[i] <= 1'b0;
            if (act_mode[i])
              clk_out[i] <= 1'b0;
          end
        end else begin
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
          // Toggle output freezes while idle unless a mode change resets it.
          if (act_mode[i] || mchg[i])
            clk_out[i] <= 1'b0;
        end

        if (apply[i]) begin
          act_div[i]  <= sh_div[i];
          act_mode[i] <= sh_mode[i];
        end

        // A write on an apply edge lands in the shadow and keeps pend set.
        if (wr_hit[i]) begin
          sh_div[i]  <= wr_div;
          sh_mode[i] <= wr_mode;
          pend[i]    <= 1'b1;
        end else if (apply[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

endmodule
